// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and hex-to-segment decode for the 7-segment scan driver
//   SEG_OFF    all segments and DP off (active-low)
//   HEX_TABLE  {DP,G..A} active-low patterns for 0..F, DP off
//   hex2seg    nibble -> 7 active-low segment bits {G,F,E,D,C,B,A}
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam logic [7:0] HEX_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [7:0] e;
        e = HEX_TABLE[nib];
        return e[6:0];
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// seg7_scan_timer: slot/digit/frame counters for the multiplexed display scan
//   clk, rst        clock, async active-high reset
//   idx             digit currently being scanned
//   phase           frame counter used as the brightness PWM phase
//   slot_start      first cycle of a digit slot (cnt==0)
//   frame_boundary  last cycle of the frame (cnt==DIV-1, idx==N_DIGITS-1)
//   blank_window    anti-ghost dark cycles at the start of each slot
module seg7_scan_timer #(
    parameter int N_DIGITS  = 4,
    parameter int DIV       = 13,
    parameter int BLANK_CYC = 1,
    parameter int BRIGHT_W  = 4,
    parameter int IW        = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    output logic [IW-1:0]       idx,
    output logic [BRIGHT_W-1:0] phase,
    output logic                slot_start,
    output logic                frame_boundary,
    output logic                blank_window
);

    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [BRIGHT_W-1:0] phase_q, phase_d;
    logic                slot_end;

    always_comb begin
        slot_end       = cnt_q == CW'(DIV - 1);
        frame_boundary = slot_end && idx_q == IW'(N_DIGITS - 1);
        cnt_d          = slot_end ? '0 : cnt_q + CW'(1);
        idx_d          = !slot_end ? idx_q : frame_boundary ? '0 : idx_q + IW'(1);
        phase_d        = frame_boundary ? phase_q + BRIGHT_W'(1) : phase_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            phase_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
        end
    end

    assign idx          = idx_q;
    assign phase        = phase_q;
    assign slot_start   = cnt_q == '0;
    assign blank_window = 32'(cnt_q) < BLANK_CYC;

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-segment driver with double buffering, LZ blanking and PWM brightness
//   clk, rst     clock, async active-high reset
//   load         capture value/dp_in into the pending buffer
//   value        hex nibbles, digit i = value[4i+3:4i]
//   dp_in        decimal point per digit, 1 = lit
//   lz_blank     blank leading zero digits (live)
//   bright       brightness, 0 = dark, all-ones = full (live)
//   digits       one-hot active-high digit enable (registered)
//   segments     {DP,G,F,E,D,C,B,A} active-low (registered)
//   frame_pulse  one-cycle pulse at the start of slot 0
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int DIV       = 13,
    parameter int BLANK_CYC = 1,
    parameter int BRIGHT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  lz_blank,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [N_DIGITS-1:0]   digits,
    output logic [7:0]            segments,
    output logic                  frame_pulse
);

    localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;

    logic [IW-1:0]         idx;
    logic [BRIGHT_W-1:0]   phase;
    logic                  slot_start, frame_boundary, blank_window;

    logic [4*N_DIGITS-1:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
    logic [N_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [N_DIGITS-1:0]   digits_q, digits_d;
    logic [7:0]            seg_q, seg_d;
    logic                  pulse_q;
    logic [3:0]            nib;
    logic                  upper_zero, blank, en;

    seg7_scan_timer #(
        .N_DIGITS (N_DIGITS),
        .DIV      (DIV),
        .BLANK_CYC(BLANK_CYC),
        .BRIGHT_W (BRIGHT_W),
        .IW       (IW)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .idx           (idx),
        .phase         (phase),
        .slot_start    (slot_start),
        .frame_boundary(frame_boundary),
        .blank_window  (blank_window)
    );

    always_comb begin
        // A load in the boundary cycle bypasses the pending buffer and wins over it.
        act_val_d    = !frame_boundary ? act_val_q : load ? value : pend_valid_q ? pend_val_q : act_val_q;
        act_dp_d     = !frame_boundary ? act_dp_q : load ? dp_in : pend_valid_q ? pend_dp_q : act_dp_q;
        pend_val_d   = (load && !frame_boundary) ? value : pend_val_q;
        pend_dp_d    = (load && !frame_boundary) ? dp_in : pend_dp_q;
        pend_valid_d = !frame_boundary && (load || pend_valid_q);
        nib          = act_val_q[4*idx +: 4];
        upper_zero   = 1'b1;
        for (int j = 0; j < N_DIGITS; j++)
            if (j >= int'(idx) && act_val_q[4*j +: 4] != 4'h0) upper_zero = 1'b0;
        blank        = lz_blank && idx != '0 && upper_zero;
        en           = !blank_window && (bright == '1 || phase < bright);
        digits_d     = en ? N_DIGITS'(1) << idx : '0;
        // Pattern is latched once per slot so live inputs cannot alter a lit digit mid-slot.
        seg_d        = slot_start ? {~act_dp_q[idx], blank ? 7'h7F : hex2seg(nib)} : seg_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_val_q    <= '0;
            act_dp_q     <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            digits_q     <= '0;
            seg_q        <= SEG_OFF;
            pulse_q      <= 1'b0;
        end else begin
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            digits_q     <= digits_d;
            seg_q        <= seg_d;
            pulse_q      <= frame_boundary;
        end
    end

    assign digits      = digits_q;
    assign segments    = seg_q;
    assign frame_pulse = pulse_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed, table-driven bench for seg7_scan_driver
module tb_seg7_scan_driver;

    logic        clk = 1'b0, rst = 1'b1, load = 1'b0, lz = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0, bright = 4'hF;
    logic [3:0]  digits;
    logic [7:0]  segments;
    logic        frame_pulse;

    logic        load8 = 1'b0;
    logic [31:0] value8 = '0;
    logic [7:0]  digits8, segments8;
    logic        pulse8;

    int n_chk = 0, n_fail = 0, pcount = 0;

    localparam logic [7:0] HEX [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dpv;
        logic        lzv;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    seg7_scan_driver #(.N_DIGITS(4), .DIV(4), .BLANK_CYC(1), .BRIGHT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .dp_in      (dp),
        .lz_blank   (lz),
        .bright     (bright),
        .digits     (digits),
        .segments   (segments),
        .frame_pulse(frame_pulse)
    );

    seg7_scan_driver #(.N_DIGITS(8), .DIV(13), .BLANK_CYC(2), .BRIGHT_W(4)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .load       (load8),
        .value      (value8),
        .dp_in      (8'h00),
        .lz_blank   (1'b0),
        .bright     (4'hF),
        .digits     (digits8),
        .segments   (segments8),
        .frame_pulse(pulse8)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        if (frame_pulse) pcount++;
    endtask

    task automatic wait_pulse(input string nm);
        int n;
        n = 0;
        while (!frame_pulse && n < 40) begin
            tick;
            n++;
        end
        chk({nm, " pulse found"}, {31'b0, frame_pulse}, 1);
    endtask

    // Starts at a frame_pulse sample; checks one full frame of 16 cycles.
    // la/lb: cycle offsets (0..15) at which a load of va/vb is captured; -1 = none.
    task automatic check_frame(input string nm, input logic [31:0] exp,
                               input int la, input logic [15:0] va,
                               input int lb, input logic [15:0] vb);
        int slot, c;
        for (int k = 1; k <= 16; k++) begin
            load  = (k - 1 == la) || (k - 1 == lb);
            value = (k - 1 == lb) ? vb : va;
            tick;
            load  = 1'b0;
            slot  = (k - 1) / 4;
            c     = (k - 1) % 4;
            chk({nm, " digits"}, {28'b0, digits}, (c == 0) ? 0 : (1 << slot));
            chk({nm, " segments"}, {24'b0, segments}, {24'b0, exp[8*slot +: 8]});
            chk({nm, " frame_pulse"}, {31'b0, frame_pulse}, (k == 16) ? 1 : 0);
        end
    endtask

    initial begin
        int n, lit, ph, slot, c;
        logic [3:0] b;
        logic [3:0] bset [3];
        vecs[0] = '{16'h1234, 4'b0000, 1'b0, 32'hF9A4B099};
        vecs[1] = '{16'h0042, 4'b1000, 1'b1, 32'h7FFF99A4};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, 32'hFFFFFFC0};
        vecs[3] = '{16'h0042, 4'b0000, 1'b0, 32'hC0C099A4};
        vecs[4] = '{16'h5678, 4'b0101, 1'b1, 32'h9202F800};
        vecs[5] = '{16'h9EF0, 4'b0000, 1'b1, 32'h90868EC0};
        vecs[6] = '{16'h0100, 4'b0000, 1'b1, 32'hFFF9C0C0};
        vecs[7] = '{16'hABCD, 4'b1111, 1'b1, 32'h08034621};
        vecs[8] = '{16'h0000, 4'b0010, 1'b1, 32'hFFFF7FC0};
        bset[0] = 4'h0;
        bset[1] = 4'h8;
        bset[2] = 4'hF;

        // Reset state and pulse timing after release
        @(posedge clk);
        #1;
        chk("reset digits", {28'b0, digits}, 0);
        chk("reset segments", {24'b0, segments}, 32'hFF);
        chk("reset frame_pulse", {31'b0, frame_pulse}, 0);
        rst = 1'b0;
        pcount = 0;
        n = 0;
        do begin tick; n++; end while (!frame_pulse && n < 40);
        chk("first pulse delay", n, 16);
        n = 0;
        do begin tick; n++; end while (!frame_pulse && n < 40);
        chk("pulse period", n, 16);

        // Asynchronous reset mid-slot with digit 2 lit
        n = 0;
        while (digits !== 4'b0100 && n < 40) begin tick; n++; end
        chk("digit2 lit before reset", {28'b0, digits}, 4);
        rst = 1'b1;
        #1;
        chk("async reset digits", {28'b0, digits}, 0);
        chk("async reset segments", {24'b0, segments}, 32'hFF);
        chk("async reset frame_pulse", {31'b0, frame_pulse}, 0);
        tick;
        rst = 1'b0;
        pcount = 0;

        // Table of display patterns
        for (int i = 0; i < 9; i++) begin
            lz    = vecs[i].lzv;
            dp    = vecs[i].dpv;
            value = vecs[i].val;
            load  = 1'b1;
            tick;
            load  = 1'b0;
            wait_pulse($sformatf("vec%0d", i));
            check_frame($sformatf("vec%0d", i), vecs[i].exp, -1, 16'h0, -1, 16'h0);
        end

        // Double buffering: mid-frame load, last load wins, boundary-cycle load
        lz    = 1'b0;
        dp    = 4'b0000;
        value = 16'h1234;
        load  = 1'b1;
        tick;
        load  = 1'b0;
        wait_pulse("dbuf");
        check_frame("dbuf hold", 32'hF9A4B099, 5, 16'hABCD, -1, 16'h0);
        check_frame("dbuf next", 32'h8883C6A1, 2, 16'h1234, 8, 16'h0042);
        check_frame("last load wins", 32'hC0C099A4, 6, 16'h1234, 15, 16'hABCD);
        check_frame("boundary load", 32'h8883C6A1, -1, 16'h0, -1, 16'h0);

        // Brightness PWM across 16 frames per setting; phase = frames since reset
        for (int s = 0; s < 3; s++) begin
            b = bset[s];
            bright = b;
            for (int f = 0; f < 16; f++) begin
                ph  = pcount % 16;
                lit = 0;
                for (int k = 0; k < 16; k++) begin
                    tick;
                    if (digits != 4'b0) lit++;
                end
                chk($sformatf("bright %0h phase %0d lit cycles", b, ph), lit,
                    (b == 4'hF || ph < int'(b)) ? 12 : 0);
            end
        end
        bright = 4'hF;

        // Eight digits, DIV=13, BLANK_CYC=2
        value8 = 32'h76543210;
        load8  = 1'b1;
        tick;
        load8  = 1'b0;
        n = 0;
        while (!pulse8 && n < 250) begin tick; n++; end
        chk("n8 pulse found", {31'b0, pulse8}, 1);
        for (int fr = 0; fr < 2; fr++) begin
            for (int k = 1; k <= 104; k++) begin
                tick;
                slot = (k - 1) / 13;
                c    = (k - 1) % 13;
                chk("n8 digits", {24'b0, digits8}, (c < 2) ? 0 : (1 << slot));
                chk("n8 segments", {24'b0, segments8}, {24'b0, HEX[slot]});
                chk("n8 frame_pulse", {31'b0, pulse8}, (k == 104) ? 1 : 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
